// File: rtl/fma_result_collector_pkg.sv
// Shared constants and types for the FMA result collector.
// Covers recFN32 field layout, flag bit positions and FIFO entry format.
package fma_result_collector_pkg;

    localparam int REC_EXP_W   = 9;
    localparam int REC_FRACT_W = 23;
    localparam int REC_W       = REC_EXP_W + REC_FRACT_W + 1;
    localparam int IEEE_W      = 32;
    localparam int TAG_W       = 5;
    localparam int FLAG_W      = 5;

    localparam logic [REC_EXP_W-1:0] MIN_NORM_EXP = 9'd130;
    localparam logic [7:0]           EXP_BIAS_ADJ = 8'd129;
    localparam logic [IEEE_W-1:0]    CANON_NAN32  = 32'h7FC00000;

    // Flag vector is {NV,DZ,OF,UF,NX}
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int LATENCY_DEFAULT = 2;
    localparam int DEPTH_DEFAULT   = 4;

    typedef struct packed {
        logic [IEEE_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [FLAG_W-1:0] flags;
    } wbEntry_t;

endpackage

// File: rtl/fma_result_collector_rec_fn_to_ieee32.sv
// Combinational recFN32 (33-bit recoded) to IEEE binary32 converter.
// Zero, infinity and NaN are decoded from the top three exponent bits.
module rec_fn_to_ieee32
    import fma_result_collector_pkg::*;
(
    input  logic [REC_W-1:0]  recIn,
    output logic [IEEE_W-1:0] ieeeOut
);

    logic                   sign;
    logic [REC_EXP_W-1:0]   expo;
    logic [REC_FRACT_W-1:0] fract;
    logic [REC_EXP_W-1:0]   shiftAmt;
    logic [REC_FRACT_W-1:0] subFract;

    assign sign  = recIn[REC_W-1];
    assign expo  = recIn[REC_W-2:REC_FRACT_W];
    assign fract = recIn[REC_FRACT_W-1:0];

    // Subnormals restore the hidden one and shift it down by the exponent deficit
    assign shiftAmt = MIN_NORM_EXP - expo;
    assign subFract = REC_FRACT_W'({1'b1, fract} >> shiftAmt);

    always_comb begin
        ieeeOut = {sign, expo[7:0] - EXP_BIAS_ADJ, fract};
        case (expo[8:6])
            3'b000: ieeeOut = {sign, 31'h0};
            3'b110: ieeeOut = {sign, 8'hFF, 23'h0};
            3'b111: ieeeOut = CANON_NAN32;
            default: begin
                if (expo < MIN_NORM_EXP) begin
                    ieeeOut = {sign, 8'h00, subFract};
                end
            end
        endcase
    end

endmodule

// File: rtl/fma_result_collector.sv
// Tracks ops through a fixed-latency FMA pipe, buffers converted results in order
// and issues credits so the result FIFO can never overflow.
module fma_result_collector
    import fma_result_collector_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_issue_valid,
    output logic                io_issue_ready,
    input  logic [TAG_W-1:0]    io_issue_tag,
    output logic                io_pipe_validin,
    input  logic [REC_W-1:0]    io_pipe_out,
    input  logic [FLAG_W-1:0]   io_pipe_exceptionFlags,
    output logic                io_wb_valid,
    input  logic                io_wb_ready,
    output logic [IEEE_W-1:0]   io_wb_data,
    output logic [TAG_W-1:0]    io_wb_tag,
    output logic [FLAG_W-1:0]   io_wb_flags,
    output logic [FLAG_W-1:0]   io_fflags,
    input  logic                io_fflags_clear
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [LATENCY-1:0] validPipe;
    logic [TAG_W-1:0]   tagPipe [LATENCY];
    wbEntry_t           fifoMem [DEPTH];
    wbEntry_t           writeEntry;
    wbEntry_t           headEntry;
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [CNT_W-1:0]   occupancy;
    logic [CNT_W-1:0]   credits;
    logic [IEEE_W-1:0]  convData;
    logic               issueFire;
    logic               fifoWrite;
    logic               wbPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    rec_fn_to_ieee32 u_conv (
        .recIn   (io_pipe_out),
        .ieeeOut (convData)
    );

    // Credits depend only on registered state, never on the writeback handshake
    assign io_issue_ready  = credits < CNT_W'(DEPTH);
    assign issueFire       = io_issue_valid & io_issue_ready;
    assign io_pipe_validin = issueFire;
    assign fifoWrite       = validPipe[LATENCY-1];
    assign io_wb_valid     = occupancy != '0;
    assign wbPop           = io_wb_valid & io_wb_ready;

    assign writeEntry = '{data: convData, tag: tagPipe[LATENCY-1], flags: io_pipe_exceptionFlags};
    assign headEntry  = fifoMem[rdPtr];
    assign io_wb_data  = io_wb_valid ? headEntry.data  : '0;
    assign io_wb_tag   = io_wb_valid ? headEntry.tag   : '0;
    assign io_wb_flags = io_wb_valid ? headEntry.flags : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            validPipe <= '0;
            for (int i = 0; i < LATENCY; i++) tagPipe[i] <= '0;
        end else begin
            validPipe[0] <= issueFire;
            tagPipe[0]   <= io_issue_tag;
            for (int i = 1; i < LATENCY; i++) begin
                validPipe[i] <= validPipe[i-1];
                tagPipe[i]   <= tagPipe[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && fifoWrite) begin
            fifoMem[wrPtr] <= writeEntry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
            credits   <= '0;
            io_fflags <= '0;
        end else begin
            if (fifoWrite) wrPtr <= nextPtr(wrPtr);
            if (wbPop)     rdPtr <= nextPtr(rdPtr);
            case ({fifoWrite, wbPop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
            case ({issueFire, wbPop})
                2'b10:   credits <= credits + CNT_W'(1);
                2'b01:   credits <= credits - CNT_W'(1);
                default: credits <= credits;
            endcase
            // A clear still keeps the flags of a result landing in the same cycle
            if (io_fflags_clear) begin
                io_fflags <= fifoWrite ? io_pipe_exceptionFlags : '0;
            end else if (fifoWrite) begin
                io_fflags <= io_fflags | io_pipe_exceptionFlags;
            end
        end
    end

endmodule

// File: tb/tb_fma_result_collector.sv
// Directed self-checking bench for fma_result_collector with a behavioural
// two-stage FMA pipe that returns the result chosen at issue time.
module tb_fma_result_collector;

    localparam int LAT = 2;

    logic        clock;
    logic        reset;
    logic        io_issue_valid;
    logic        io_issue_ready;
    logic [4:0]  io_issue_tag;
    logic        io_pipe_validin;
    logic [32:0] io_pipe_out;
    logic [4:0]  io_pipe_exceptionFlags;
    logic        io_wb_valid;
    logic        io_wb_ready;
    logic [31:0] io_wb_data;
    logic [4:0]  io_wb_tag;
    logic [4:0]  io_wb_flags;
    logic [4:0]  io_fflags;
    logic        io_fflags_clear;

    logic [32:0] opOut;
    logic [4:0]  opFlags;
    logic [37:0] pipeStage [LAT];

    int errorCount = 0;
    int checkCount = 0;

    fma_result_collector #(.LATENCY(LAT), .DEPTH(4)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_issue_valid         (io_issue_valid),
        .io_issue_ready         (io_issue_ready),
        .io_issue_tag           (io_issue_tag),
        .io_pipe_validin        (io_pipe_validin),
        .io_pipe_out            (io_pipe_out),
        .io_pipe_exceptionFlags (io_pipe_exceptionFlags),
        .io_wb_valid            (io_wb_valid),
        .io_wb_ready            (io_wb_ready),
        .io_wb_data             (io_wb_data),
        .io_wb_tag              (io_wb_tag),
        .io_wb_flags            (io_wb_flags),
        .io_fflags              (io_fflags),
        .io_fflags_clear        (io_fflags_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // FMA pipe stand-in: the value offered with an issue emerges LAT cycles later
    always @(posedge clock) begin
        pipeStage[0] <= {opOut, opFlags};
        for (int i = 1; i < LAT; i++) pipeStage[i] <= pipeStage[i-1];
    end
    assign io_pipe_out            = pipeStage[LAT-1][37:5];
    assign io_pipe_exceptionFlags = pipeStage[LAT-1][4:0];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] tag, input logic [32:0] out,
                                 input logic [4:0] flags, input logic wbReady, input logic clear);
        io_issue_valid  = valid;
        io_issue_tag    = tag;
        opOut           = out;
        opFlags         = flags;
        io_wb_ready     = wbReady;
        io_fflags_clear = clear;
        #1;
    endtask

    task automatic runSingle(input logic [4:0] tag, input logic [32:0] out, input logic [4:0] flags,
                             input logic [31:0] expData, input logic [4:0] expFflags);
        int lat;
        applyStimulus(1'b1, tag, out, flags, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b1, 1'b0);
        lat = 1;
        while (!io_wb_valid && lat < 10) begin
            nextCycle();
            lat++;
        end
        checkOutput("single_latency", 32'(lat), 32'd3);
        checkOutput("single_data", io_wb_data, expData);
        checkOutput("single_tag", 32'(io_wb_tag), 32'(tag));
        checkOutput("single_wbflags", 32'(io_wb_flags), 32'(flags));
        checkOutput("single_fflags", 32'(io_fflags), 32'(expFflags));
        nextCycle();
    endtask

    logic [32:0] seqOut  [3] = '{33'h0C0000000, 33'h000000000, 33'h0E0000000};
    logic [31:0] seqData [3] = '{32'h7F800000, 32'h00000000, 32'h7FC00000};

    initial begin
        int got;
        int fires;
        int seen;

        reset = 1'b1;
        applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b0, 1'b0);
        repeat (3) nextCycle();
        reset = 1'b0;
        #1;
        checkOutput("rst_wb_valid", 32'(io_wb_valid), 32'd0);
        checkOutput("rst_issue_ready", 32'(io_issue_ready), 32'd1);
        checkOutput("rst_wb_data", io_wb_data, 32'd0);
        checkOutput("rst_wb_tag", 32'(io_wb_tag), 32'd0);
        checkOutput("rst_wb_flags", 32'(io_wb_flags), 32'd0);
        checkOutput("rst_fflags", 32'(io_fflags), 32'd0);

        // Tag 3 issued in cycle 0 must appear no earlier than cycle 3
        nextCycle();
        applyStimulus(1'b1, 5'd3, 33'h080000000, 5'd0, 1'b0, 1'b0);
        checkOutput("pipe_validin", 32'(io_pipe_validin), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("no_wb_c1", 32'(io_wb_valid), 32'd0);
        nextCycle();
        checkOutput("no_wb_c2", 32'(io_wb_valid), 32'd0);
        nextCycle();
        checkOutput("wb_c3_valid", 32'(io_wb_valid), 32'd1);
        checkOutput("wb_c3_data", io_wb_data, 32'h3F800000);
        checkOutput("wb_c3_tag", 32'(io_wb_tag), 32'd3);
        checkOutput("wb_c3_fflags", 32'(io_fflags), 32'd0);
        applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("pop_empty", 32'(io_wb_valid), 32'd0);

        runSingle(5'd4, 33'h040800000, 5'b00011, 32'h00400000, 5'b00011);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(5 + i), seqOut[i], 5'd0, 1'b1, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b1, 1'b0);
        got = 0;
        for (int c = 0; c < 10; c++) begin
            if (io_wb_valid) begin
                if (got < 3) begin
                    checkOutput("special_data", io_wb_data, seqData[got]);
                    checkOutput("special_tag", 32'(io_wb_tag), 32'(5 + got));
                end
                got++;
            end
            nextCycle();
        end
        checkOutput("special_count", 32'(got), 32'd3);

        // Backpressure: credits run out after DEPTH fires
        fires = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 5'(8 + fires), 33'h080000000 + 33'(fires), 5'd0, 1'b0, 1'b0);
            if (io_issue_ready) fires++;
            nextCycle();
        end
        applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("bp_fires", 32'(fires), 32'd4);
        checkOutput("bp_ready_low", 32'(io_issue_ready), 32'd0);
        checkOutput("bp_buffered", 32'(io_wb_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b1, 1'b0);
            checkOutput("bp_order_data", io_wb_data, 32'h3F800000 + 32'(i));
            checkOutput("bp_order_tag", 32'(io_wb_tag), 32'(8 + i));
            nextCycle();
            if (i == 0) checkOutput("bp_credit_back", 32'(io_issue_ready), 32'd1);
        end
        checkOutput("bp_drained", 32'(io_wb_valid), 32'd0);

        // Sticky flags: clear alone, then clear colliding with a write
        applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b1, 1'b0);
        checkOutput("clear_only", 32'(io_fflags), 32'd0);
        runSingle(5'd12, 33'h080000000, 5'b00001, 32'h3F800000, 5'b00001);
        applyStimulus(1'b1, 5'd13, 33'h080000000, 5'b10000, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("clear_with_write", 32'(io_fflags), 32'b10000);
        checkOutput("clear_wb_flags", 32'(io_wb_flags), 32'b10000);
        applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b1, 1'b0);
        nextCycle();

        // Reset with two results buffered and two in flight
        applyStimulus(1'b1, 5'd20, 33'h080000000, 5'd0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd21, 33'h080000000, 5'd0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) nextCycle();
        applyStimulus(1'b1, 5'd22, 33'h080000000, 5'd0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd23, 33'h080000000, 5'd0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 33'd0, 5'd0, 1'b1, 1'b0);
        checkOutput("prerst_buffered", 32'(io_wb_valid), 32'd1);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        #1;
        checkOutput("postrst_valid", 32'(io_wb_valid), 32'd0);
        checkOutput("postrst_ready", 32'(io_issue_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            if (io_wb_valid) seen++;
        end
        checkOutput("postrst_no_wb", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
